// File: rtl/tile_compositor.sv
// Composes one frame of tile codes (background plus prioritised sprite slots) into a
// stream of framebuffer writes through a two-stage pipeline.
module tile_compositor #(
    parameter int NUM_SPR = 4,
    parameter int TILES_X = 32,
    parameter int TILES_Y = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic [7:0]             bg_code,
    input  logic [5*NUM_SPR-1:0]   spr_x,
    input  logic [5*NUM_SPR-1:0]   spr_y,
    input  logic [8*NUM_SPR-1:0]   spr_code,
    input  logic [NUM_SPR-1:0]     spr_en,
    output logic [9:0]             addrWrite,
    output logic [7:0]             dataWrite,
    output logic                   wr_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int TXW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
    localparam int TYW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                 state;
    state_t                 nextState;
    logic [TXW-1:0]         tx;
    logic [TYW-1:0]         ty;
    logic [TXW-1:0]         curTx;
    logic [TYW-1:0]         curTy;
    logic                   issue;
    logic                   isLast;

    logic [7:0]             snapBg;
    logic [5*NUM_SPR-1:0]   snapX;
    logic [5*NUM_SPR-1:0]   snapY;
    logic [8*NUM_SPR-1:0]   snapCode;
    logic [NUM_SPR-1:0]     snapEn;

    logic [5*NUM_SPR-1:0]   srcX;
    logic [5*NUM_SPR-1:0]   srcY;
    logic [NUM_SPR-1:0]     srcEn;

    logic [NUM_SPR-1:0]     curHit;
    logic [9:0]             curAddr;
    logic                   s1Valid;
    logic [NUM_SPR-1:0]     s1Hit;
    logic [9:0]             s1Addr;
    logic [7:0]             outData;

    // The start edge issues tile 0 straight from the live inputs, so the first write
    // lands one cycle after the start edge; later tiles use the snapshot.
    assign srcX  = frame_start ? spr_x  : snapX;
    assign srcY  = frame_start ? spr_y  : snapY;
    assign srcEn = frame_start ? spr_en : snapEn;

    assign isLast = (tx == TXW'(TILES_X - 1)) && (ty == TYW'(TILES_Y - 1));
    assign busy   = (state != IDLE);

    always_comb begin
        nextState = state;
        issue     = 1'b0;
        curTx     = tx;
        curTy     = ty;
        if (frame_start) begin
            nextState = RUN;
            issue     = 1'b1;
            curTx     = '0;
            curTy     = '0;
        end else begin
            case (state)
                IDLE: nextState = IDLE;
                RUN: begin
                    if (isLast) begin
                        nextState = FLUSH;
                    end else begin
                        issue = 1'b1;
                        if (tx == TXW'(TILES_X - 1)) begin
                            curTx = '0;
                            curTy = ty + 1'b1;
                        end else begin
                            curTx = tx + 1'b1;
                        end
                    end
                end
                FLUSH:   nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // Full-width coordinate compares keep out-of-range sprites from aliasing onto a row.
    always_comb begin
        curHit  = '0;
        curAddr = 10'(curTy) * 10'(TILES_X) + 10'(curTx);
        for (int i = 0; i < NUM_SPR; i++) begin
            curHit[i] = srcEn[i] && (srcX[5*i +: 5] == 5'(curTx)) && (srcY[5*i +: 5] == 5'(curTy));
        end
    end

    always_comb begin
        outData = snapBg;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (s1Hit[i]) begin
                outData = snapCode[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= '0;
            ty       <= '0;
            snapBg   <= '0;
            snapX    <= '0;
            snapY    <= '0;
            snapCode <= '0;
            snapEn   <= '0;
            s1Valid  <= 1'b0;
            s1Hit    <= '0;
            s1Addr   <= '0;
        end else begin
            state   <= nextState;
            s1Valid <= issue;
            if (issue) begin
                tx     <= curTx;
                ty     <= curTy;
                s1Hit  <= curHit;
                s1Addr <= curAddr;
            end
            if (frame_start) begin
                snapBg   <= bg_code;
                snapX    <= spr_x;
                snapY    <= spr_y;
                snapCode <= spr_code;
                snapEn   <= spr_en;
            end
        end
    end

    // Stage 2 reads the snapshot before a restart overwrites it, so in-flight tiles keep old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrWrite <= '0;
            dataWrite <= '0;
            wr_valid  <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            wr_valid <= s1Valid;
            if (s1Valid) begin
                addrWrite <= s1Addr;
                dataWrite <= outData;
            end
            done    <= (state == FLUSH) && !frame_start;
            overrun <= overrun | (frame_start && (state != IDLE));
        end
    end

endmodule

// File: tb/tb_tile_compositor.sv
// Self-checking bench for tile_compositor: table-driven frames with a write scoreboard,
// plus hand-written overrun, final-tile restart and mid-frame reset sequences.
module tb_tile_compositor;

    localparam int NUM_SPR = 4;
    localparam int TILES_X = 32;
    localparam int TILES_Y = 24;
    localparam int NTILES  = TILES_X * TILES_Y;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 frame_start;
    logic [7:0]           bg_code;
    logic [5*NUM_SPR-1:0] spr_x;
    logic [5*NUM_SPR-1:0] spr_y;
    logic [8*NUM_SPR-1:0] spr_code;
    logic [NUM_SPR-1:0]   spr_en;
    logic [9:0]           addrWrite;
    logic [7:0]           dataWrite;
    logic                 wr_valid;
    logic                 busy;
    logic                 done;
    logic                 overrun;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  bg;
        logic [19:0] x;
        logic [19:0] y;
        logic [31:0] code;
        logic [3:0]  en;
        logic [9:0]  probeAddr;
        logic [7:0]  probeData;
        logic [7:0]  forbid;
    } vec_t;

    wr_t  expQ[$];
    vec_t vecs[4];
    vec_t vChg;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    int doneCount = 0;
    int doneCycle = 0;
    int writeCount = 0;
    int forbidCount = 0;
    int probeSeen = 0;
    int e0 = 0;
    logic [7:0] probeGot;
    logic [7:0] forbidCode;
    logic [9:0] probeAddr;

    tile_compositor #(.NUM_SPR(NUM_SPR), .TILES_X(TILES_X), .TILES_Y(TILES_Y)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .bg_code(bg_code),
        .spr_x(spr_x),
        .spr_y(spr_y),
        .spr_code(spr_code),
        .spr_en(spr_en),
        .addrWrite(addrWrite),
        .dataWrite(dataWrite),
        .wr_valid(wr_valid),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, 32'({addrWrite, dataWrite, wr_valid, busy, done, overrun}), 32'd0);
    endtask

    // Reference: lowest enabled slot whose column/row match the tile wins, else background.
    function automatic logic [7:0] modelData(input int a, input vec_t v);
        int tx = a % TILES_X;
        int ty = a / TILES_X;
        logic [7:0] d = v.bg;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (v.en[i] && int'(v.x[5*i +: 5]) == tx && int'(v.y[5*i +: 5]) == ty) begin
                d = v.code[8*i +: 8];
            end
        end
        return d;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bg_code  = v.bg;
        spr_x    = v.x;
        spr_y    = v.y;
        spr_code = v.code;
        spr_en   = v.en;
    endtask

    task automatic pushFrame(input vec_t v);
        wr_t w;
        for (int a = 0; a < NTILES; a++) begin
            w.addr = 10'(a);
            w.data = modelData(a, v);
            expQ.push_back(w);
        end
    endtask

    // Advance one clock and score whatever the DUT presents after that edge.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (wr_valid) begin
            writeCount++;
            if (dataWrite == forbidCode) forbidCount++;
            if (addrWrite == probeAddr) begin
                probeSeen++;
                probeGot = dataWrite;
            end
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", addrWrite, dataWrite);
            end else begin
                e = expQ.pop_front();
                checkOutput("write_addr", 32'(addrWrite), 32'(e.addr));
                checkOutput("write_data", 32'(dataWrite), 32'(e.data));
            end
        end
        if (done) begin
            doneCount++;
            doneCycle = cycle;
        end
    endtask

    task automatic startFrame(input vec_t v);
        applyStimulus(v);
        pushFrame(v);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        e0 = cycle;
    endtask

    task automatic waitDone(input int bound);
        int n = 0;
        int startDone = doneCount;
        while (doneCount == startDone && n < bound) begin
            tick();
            n++;
        end
        if (doneCount == startDone) begin
            tests++;
            fails++;
            $display("[TB] FAIL done_timeout: got no done in %0d cycles, expected a done pulse", bound);
        end
    endtask

    task automatic keepInFlight();
        while (expQ.size() > 1) void'(expQ.pop_back());
    endtask

    task automatic runFrame(input vec_t v, input int changeAt, input vec_t vNew);
        probeAddr   = v.probeAddr;
        forbidCode  = v.forbid;
        probeGot    = 8'h00;
        writeCount  = 0;
        forbidCount = 0;
        probeSeen   = 0;
        doneCount   = 0;
        startFrame(v);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        if (changeAt > 0) begin
            repeat (changeAt - 1) tick();
            applyStimulus(vNew);
        end
        waitDone(NTILES + 40);
        checkOutput("done_latency", 32'(doneCycle - e0), 32'd769);
        checkOutput("quiet_at_done", 32'({wr_valid, busy}), 32'd0);
        checkOutput("hold_addr", 32'(addrWrite), 32'd767);
        checkOutput("write_count", 32'(writeCount), 32'(NTILES));
        checkOutput("probe_seen", 32'(probeSeen), 32'd1);
        checkOutput("probe_data", 32'(probeGot), 32'(v.probeData));
        checkOutput("forbidden_code", 32'(forbidCount), 32'd0);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        tick();
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("done_count", 32'(doneCount), 32'd1);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkAllZero("reset_zero");
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'h11, 20'h0, 20'h0, 32'h0, 4'b0000, 10'd0, 8'h11, 8'h00};
        vecs[1] = '{8'h22, {5'd0, 5'd0, 5'd5, 5'd5}, {5'd0, 5'd0, 5'd3, 5'd3},
                    {8'h00, 8'h00, 8'hB0, 8'hA0}, 4'b0011, 10'd101, 8'hA0, 8'hB0};
        vecs[2] = '{8'h33, {5'd31, 5'd31, 5'd0, 5'd0}, {5'd24, 5'd23, 5'd0, 5'd0},
                    {8'hEE, 8'h7F, 8'h00, 8'h00}, 4'b1100, 10'd767, 8'h7F, 8'hEE};
        vecs[3] = '{8'h44, 20'h0, 20'h0, {8'h00, 8'h00, 8'h55, 8'h66}, 4'b0010, 10'd0, 8'h55, 8'h66};

        rst_n       = 1'b0;
        frame_start = 1'b0;
        probeAddr   = 10'd0;
        forbidCode  = 8'h00;
        probeGot    = 8'h00;
        applyStimulus(vecs[0]);
        #3;
        checkAllZero("reset_state");
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            checkAllZero("idle_hold");
        end

        for (int i = 0; i < 4; i++) begin
            runFrame(vecs[i], 0, vecs[i]);
            checkOutput("no_overrun", 32'(overrun), 32'd0);
        end

        // Inputs changed mid-frame must not affect the running frame, only the next one.
        vChg = vecs[1];
        vChg.x[4:0]    = 5'd10;
        vChg.code[7:0] = 8'hC0;
        begin
            vec_t vCur;
            vCur = vecs[1];
            vCur.forbid = 8'hC0;
            runFrame(vCur, 100, vChg);
        end
        vChg.probeAddr = 10'd106;
        vChg.probeData = 8'hC0;
        vChg.forbid    = 8'hA0;
        runFrame(vChg, 0, vChg);

        // Overrun at cycle 300: one in-flight write, then a full restarted frame.
        doneCount = 0;
        startFrame(vecs[0]);
        repeat (299) tick();
        checkOutput("overrun_before", 32'(overrun), 32'd0);
        keepInFlight();
        applyStimulus(vecs[2]);
        pushFrame(vecs[2]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        e0 = cycle;
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        checkOutput("busy_restart", 32'(busy), 32'd1);
        waitDone(NTILES + 40);
        checkOutput("overrun_done_latency", 32'(doneCycle - e0), 32'd769);
        checkOutput("overrun_done_count", 32'(doneCount), 32'd1);
        checkOutput("overrun_queue", 32'(expQ.size()), 32'd0);
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);

        // frame_start arriving with the final tile in the pipeline counts as an overrun.
        pulseReset();
        doneCount = 0;
        startFrame(vecs[3]);
        repeat (767) tick();
        keepInFlight();
        applyStimulus(vecs[1]);
        pushFrame(vecs[1]);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        e0 = cycle;
        checkOutput("final_tile_overrun", 32'(overrun), 32'd1);
        waitDone(NTILES + 40);
        checkOutput("final_tile_done_count", 32'(doneCount), 32'd1);
        checkOutput("final_tile_latency", 32'(doneCycle - e0), 32'd769);
        checkOutput("final_tile_queue", 32'(expQ.size()), 32'd0);

        // Asynchronous reset mid-frame: outputs clear without a clock, no more writes or done.
        doneCount = 0;
        startFrame(vecs[1]);
        repeat (50) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        expQ.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checkAllZero("after_reset_idle");
        end
        checkOutput("after_reset_no_done", 32'(doneCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
